// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter.
// Grants a whole message, with registered output and stall watchdog.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int STALL_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 stall_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } state_t;

  localparam logic [23:0] STALL_LIM =
    24'(STALL_CYCLES);

  state_t      state;
  logic [23:0] stallCnt;
  logic [2:0]  rrPtr;
  logic [2:0]  pick;
  logic [3:0]  idx;
  logic [7:0]  vPad;
  logic [7:0]  lPad;
  logic [63:0] dPad;
  logic [7:0]  selByte;
  logic        selValid;
  logic        selLast;
  logic        slotFree;
  logic        canTake;
  logic        accept;
  logic        anyReq;

  assign vPad = 8'(req_valid);
  assign lPad = 8'(req_last);
  assign dPad = 64'(req_data);

  assign selValid = vPad[grant_id];
  assign selLast  = lPad[grant_id];
  assign selByte  = dPad[{grant_id, 3'b000} +: 8];

  assign slotFree = !tx_valid || tx_ready;
  assign canTake  = (state == GRANT) && slotFree;
  assign accept   = canTake && selValid;
  assign anyReq   = |req_valid;

  assign req_ready = canTake ?
    NUM_REQ'(8'd1 << grant_id) : '0;

  // Walk from farthest to nearest so the
  // source right after rrPtr wins.
  always_comb begin
    pick = rrPtr;
    idx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = {1'b0, rrPtr} + 4'(i);
      if (idx >= 4'(NUM_REQ))
        idx = idx - 4'(NUM_REQ);
      if (vPad[idx[2:0]])
        pick = idx[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stallCnt  <= '0;
      rrPtr     <= 3'(NUM_REQ - 1);
      grant_id  <= '0;
      busy      <= 1'b0;
      stall_err <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      stall_err <= 1'b0;
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= selByte;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            grant_id <= pick;
            rrPtr    <= pick;
            stallCnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept && selLast) begin
            stallCnt <= '0;
            state    <= DRAIN;
          end else if (selValid) begin
            stallCnt <= '0;
          end else if (stallCnt + 24'd1
                       == STALL_LIM) begin
            stallCnt  <= '0;
            stall_err <= 1'b1;
            state     <= DRAIN;
          end else begin
            stallCnt <= stallCnt + 24'd1;
          end
        end
        DRAIN: begin
          if (slotFree) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter with a
// cycle-level behavioural model and directed cases.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int STALL = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b1;
  logic [2:0]     grant_id;
  logic           busy;
  logic           stall_err;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .grant_id(grant_id),
    .busy(busy),
    .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic       last;
    logic [7:0] data;
  } ent_t;

  ent_t q [N][$];
  bit   pres [N];
  bit   armed [N];
  int   gapLeft [N];
  int   accEdge [N];

  int checks = 0;
  int errors = 0;
  int txMode = 0;
  int cyc = 0;

  logic [7:0] txLog [$];
  int grantLog [$];
  int stallSeen, stallEdge;
  int firstReq, firstGrant;
  int busyCyc, txFirst, txLastCyc;
  bit prevBusy;

  // model: who owns the line, and what sits in
  // the one-byte output slot
  int         mOwn;
  bit         mDrain;
  int         mRun;
  bit         mFull;
  logic [7:0] mByte;
  int         mLast;
  bit         mErr;
  int         mId;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic mReset();
    mOwn   = -1;
    mDrain = 0;
    mRun   = 0;
    mFull  = 0;
    mByte  = '0;
    mLast  = N - 1;
    mErr   = 0;
    mId    = 0;
  endtask

  task automatic mAdvance(logic [N-1:0] rdy);
    bit wasFree;
    bit acc;
    int s;
    wasFree = !mFull || tx_ready;
    acc = (rdy & req_valid) != '0;
    mErr = 0;
    if (acc) begin
      mFull = 1;
      mByte = req_data[8*mOwn +: 8];
    end else if (tx_ready) begin
      mFull = 0;
    end
    if (mOwn < 0) begin
      for (int k = 1; k <= N; k++) begin
        s = (mLast + k) % N;
        if (req_valid[s]) begin
          mOwn = s;
          mLast = s;
          mId = s;
          mRun = 0;
          break;
        end
      end
    end else if (!mDrain) begin
      if (acc && req_last[mOwn]) begin
        mDrain = 1;
      end else if (req_valid[mOwn]) begin
        mRun = 0;
      end else begin
        mRun++;
        if (mRun == STALL) begin
          mErr = 1;
          mDrain = 1;
          mRun = 0;
        end
      end
    end else if (wasFree) begin
      mOwn = -1;
      mDrain = 0;
    end
  endtask

  initial begin
    logic [N-1:0] expRdy;
    forever begin
      @(negedge clk);
      if (!rst_n) mReset();
      expRdy = '0;
      if (mOwn >= 0 && !mDrain &&
          (!mFull || tx_ready))
        expRdy[mOwn] = 1'b1;
      chk("tx_valid", 32'(tx_valid), 32'(mFull));
      chk("tx_data", 32'(tx_data), 32'(mByte));
      chk("busy", 32'(busy), 32'(mOwn >= 0));
      chk("grant_id", 32'(grant_id), mId);
      chk("stall_err", 32'(stall_err), 32'(mErr));
      chk("req_ready", 32'(req_ready), 32'(expRdy));
      chk("ready_onehot",
          32'($countones(req_ready) <= 1), 1);
      if (rst_n) mAdvance(expRdy);
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && q[i].size() > 0) begin
        if (!armed[i]) begin
          gapLeft[i] = q[i][0].gap;
          armed[i] = 1;
        end
        if (gapLeft[i] > 0) begin
          gapLeft[i]--;
        end else begin
          pres[i] = 1;
          armed[i] = 0;
        end
      end
      req_valid[i] = pres[i];
      if (pres[i]) begin
        req_data[8*i +: 8] = q[i][0].data;
        req_last[i] = q[i][0].last;
      end else begin
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    case (txMode)
      0: tx_ready = 1'b1;
      1: tx_ready = $urandom_range(0, 3) != 0;
      default: tx_ready = (cyc % 3) == 0;
    endcase
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (tx_valid && tx_ready) begin
      txLog.push_back(tx_data);
      if (txFirst < 0) txFirst = cyc;
      txLastCyc = cyc;
    end
    if (req_valid != '0 && firstReq < 0)
      firstReq = cyc;
    if (busy && !prevBusy) begin
      grantLog.push_back(int'(grant_id));
      if (firstGrant < 0) firstGrant = cyc;
    end
    if (busy) busyCyc++;
    prevBusy = busy;
    if (stall_err) begin
      stallSeen++;
      stallEdge = cyc;
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(q[i].pop_front());
        pres[i] = 0;
        accEdge[i] = cyc;
      end
    end
    #1;
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      pres[i] = 0;
      armed[i] = 0;
    end
    req_valid = '0;
  endtask

  task automatic clearLogs();
    txLog.delete();
    grantLog.delete();
    stallSeen = 0;
    stallEdge = -1;
    firstReq = -1;
    firstGrant = -1;
    busyCyc = 0;
    txFirst = -1;
    txLastCyc = -1;
    prevBusy = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    flush();
    step();
    step();
    rst_n = 1'b1;
    clearLogs();
  endtask

  task automatic pushB(int s, int gap,
                       logic last,
                       logic [7:0] d);
    ent_t e;
    e.gap = gap;
    e.last = last;
    e.data = d;
    q[s].push_back(e);
  endtask

  task automatic waitIdle(string name, int lim);
    bit ok;
    bit quiet;
    ok = 0;
    for (int n = 0; n < lim; n++) begin
      step();
      quiet = !busy && !tx_valid;
      for (int i = 0; i < N; i++)
        if (q[i].size() != 0 || pres[i])
          quiet = 0;
      if (quiet) begin
        ok = 1;
        break;
      end
    end
    step();
    chk({"idle_", name}, 32'(ok), 1);
  endtask

  initial begin
    logic [7:0] exp8 [$];
    int expG [$];
    int len;
    bit got;
    mReset();
    clearLogs();
    flush();

    // source 2 alone sends "OK\n"
    doReset();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_stall", 32'(stall_err), 0);
    pushB(2, 0, 1'b0, 8'h4F);
    pushB(2, 0, 1'b0, 8'h4B);
    pushB(2, 0, 1'b1, 8'h0A);
    waitIdle("ok", 50);
    chk("ok_len", 32'(txLog.size()), 3);
    if (txLog.size() == 3) begin
      chk("ok_b0", 32'(txLog[0]), 32'h4F);
      chk("ok_b1", 32'(txLog[1]), 32'h4B);
      chk("ok_b2", 32'(txLog[2]), 32'h0A);
    end
    chk("ok_gid", grantLog.size() > 0 ?
        grantLog[0] : -1, 2);
    chk("ok_arb_delay", firstGrant - firstReq, 1);
    chk("ok_tx_span", txLastCyc - txFirst, 2);
    chk("ok_busy_cycles", busyCyc, 4);

    // all four sources, two-byte messages
    doReset();
    exp8.delete();
    for (int s = 0; s < N; s++) begin
      pushB(s, 0, 1'b0, 8'(s * 16 + 1));
      pushB(s, 0, 1'b1, 8'(s * 16 + 2));
      exp8.push_back(8'(s * 16 + 1));
      exp8.push_back(8'(s * 16 + 2));
    end
    waitIdle("all4", 100);
    chk("all4_len", 32'(txLog.size()), 8);
    for (int k = 0; k < 8 && k < txLog.size(); k++)
      chk("all4_byte", 32'(txLog[k]), 32'(exp8[k]));
    for (int k = 0; k < 4 && k < grantLog.size(); k++)
      chk("all4_order", grantLog[k], k);

    // 1 wins, then 1 and 3 together
    doReset();
    pushB(1, 0, 1'b1, 8'h77);
    waitIdle("rr_a", 50);
    pushB(1, 0, 1'b1, 8'h78);
    pushB(3, 0, 1'b1, 8'h79);
    waitIdle("rr_b", 50);
    expG = '{1, 3, 1};
    chk("rr_len", 32'(grantLog.size()), 3);
    for (int k = 0; k < 3 && k < grantLog.size(); k++)
      chk("rr_order", grantLog[k], expG[k]);

    // back-pressure pattern 1,0,0
    doReset();
    txMode = 2;
    exp8.delete();
    for (int k = 0; k < 5; k++) begin
      pushB(3, 0, 1'(k == 4), 8'(8'hC0 + k));
      exp8.push_back(8'(8'hC0 + k));
    end
    waitIdle("bp", 100);
    chk("bp_len", 32'(txLog.size()), 5);
    for (int k = 0; k < 5 && k < txLog.size(); k++)
      chk("bp_byte", 32'(txLog[k]), 32'(exp8[k]));
    chk("bp_no_stall", stallSeen, 0);
    txMode = 0;

    // source 0 goes silent after one byte
    doReset();
    pushB(0, 0, 1'b0, 8'hA5);
    pushB(1, 0, 1'b0, 8'h10);
    pushB(1, 0, 1'b1, 8'h11);
    waitIdle("stall", 100);
    chk("stall_count", stallSeen, 1);
    chk("stall_timing", stallEdge - accEdge[0], 4);
    chk("stall_byte", txLog.size() > 0 ?
        32'(txLog[0]) : 32'hFFFF, 32'hA5);
    expG = '{0, 1};
    chk("stall_glen", 32'(grantLog.size()), 2);
    for (int k = 0; k < 2 && k < grantLog.size(); k++)
      chk("stall_order", grantLog[k], expG[k]);

    // valid returns on the would-expire cycle
    doReset();
    pushB(0, 0, 1'b0, 8'h21);
    pushB(0, STALL - 1, 1'b1, 8'h22);
    waitIdle("vwin", 100);
    chk("vwin_stall", stallSeen, 0);
    chk("vwin_len", 32'(txLog.size()), 2);
    chk("vwin_glen", 32'(grantLog.size()), 1);

    // one cycle later it does expire
    doReset();
    pushB(0, 0, 1'b0, 8'h33);
    pushB(0, STALL, 1'b1, 8'h44);
    waitIdle("vlate", 100);
    chk("vlate_stall", stallSeen, 1);
    chk("vlate_glen", 32'(grantLog.size()), 2);
    chk("vlate_len", 32'(txLog.size()), 2);

    // reset mid-message
    doReset();
    txMode = 2;
    for (int k = 0; k < 6; k++)
      pushB(2, 0, 1'(k == 5), 8'(k + 1));
    got = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (tx_valid) begin
        got = 1;
        break;
      end
    end
    chk("mid_txv_seen", 32'(got), 1);
    chk("mid_gid_pre", 32'(grant_id), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_txv", 32'(tx_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_gid", 32'(grant_id), 0);
    flush();
    step();
    step();
    rst_n = 1'b1;
    clearLogs();
    txMode = 0;
    pushB(3, 0, 1'b1, 8'h55);
    pushB(0, 0, 1'b1, 8'h66);
    waitIdle("mid_after", 50);
    chk("mid_first", grantLog.size() > 0 ?
        grantLog[0] : -1, 0);

    // randomised traffic
    doReset();
    txMode = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < N; s++) begin
        if (q[s].size() == 0 && !pres[s] &&
            $urandom_range(0, 7) == 0) begin
          len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++)
            pushB(s,
              $urandom_range(0, 9) > 7 ?
                $urandom_range(1, 6) : 0,
              1'(k == len - 1),
              8'($urandom));
        end
      end
      step();
    end
    waitIdle("random", 3000);
    txMode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
